// File: rtl/evaluate_mob_sum_pkg.sv
// Shared constants for the per-square mobility evaluators and their reducer.
// Term k of a packed bus sits at [term_lsb(k, width) +: width].
package evaluate_mob_sum_pkg;

  localparam int EVAL_WIDTH_DEF = 16;
  localparam int PIECE_TYPES = 4;
  localparam int COLOURS = 2;
  localparam int SQUARES = 64;
  localparam int MOB_TERMS_PER_PIECE = COLOURS * SQUARES;
  localparam int TERM_COUNT_DEF = PIECE_TYPES * MOB_TERMS_PER_PIECE;
  localparam int UPSTREAM_LATENCY_DEF = 4;

  function automatic int term_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/evaluate_mob_sum_level.sv
// One registered level of the mobility adder tree.
// Pairs adjacent entries; all arithmetic is at the full tree width.
module evaluate_mob_sum_level
  import evaluate_mob_sum_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 16
) (
  input  logic               clk,
  input  logic [N*W-1:0]     d_i,
  output logic [(N/2)*W-1:0] q_o
);

  localparam int M = N / 2;

  logic [M*W-1:0] sum_d;
  logic [M*W-1:0] sum_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < M; i++) begin
      sum_d[term_lsb(i, W) +: W] =
        d_i[term_lsb(2*i, W) +: W] +
        d_i[term_lsb(2*i+1, W) +: W];
    end
  end

  always_ff @(posedge clk) begin
    sum_q <= sum_d;
  end

  assign q_o = sum_q;

endmodule

// File: rtl/evaluate_mob_sum.sv
// Mobility reduction: stage-0 capture, registered adder tree, saturation,
// and a valid delay line aligned to the upstream evaluators.
module evaluate_mob_sum
  import evaluate_mob_sum_pkg::*;
#(
  parameter int EVAL_WIDTH       = EVAL_WIDTH_DEF,
  parameter int TERM_COUNT       = TERM_COUNT_DEF,
  parameter int UPSTREAM_LATENCY = UPSTREAM_LATENCY_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           board_valid,
  input  logic [TERM_COUNT*EVAL_WIDTH-1:0] eval_mg_in,
  input  logic [TERM_COUNT*EVAL_WIDTH-1:0] eval_eg_in,
  output logic [EVAL_WIDTH-1:0]          eval_mg,
  output logic [EVAL_WIDTH-1:0]          eval_eg,
  output logic                           eval_valid,
  output logic                           eval_saturated
);

  localparam int LEVELS = $clog2(TERM_COUNT);
  localparam int LEAVES = 1 << LEVELS;
  localparam int SW     = EVAL_WIDTH + LEVELS;
  localparam int NODES  = 2 * LEAVES - 1;
  localparam int ROOT   = NODES - 1;
  localparam int DEPTH  = UPSTREAM_LATENCY + LEVELS + 2;

  localparam logic [SW-1:0] MAX_S =
    {{(LEVELS+1){1'b0}}, {(EVAL_WIDTH-1){1'b1}}};
  localparam logic [SW-1:0] MIN_S = ~MAX_S;

  function automatic logic [SW-1:0] sext(
    input logic [EVAL_WIDTH-1:0] v
  );
    return {{LEVELS{v[EVAL_WIDTH-1]}}, v};
  endfunction

  // {clamped, value}
  function automatic logic [EVAL_WIDTH:0] clamp(
    input logic [SW-1:0] v
  );
    if ($signed(v) > $signed(MAX_S))
      return {1'b1, MAX_S[EVAL_WIDTH-1:0]};
    if ($signed(v) < $signed(MIN_S))
      return {1'b1, MIN_S[EVAL_WIDTH-1:0]};
    return {1'b0, v[EVAL_WIDTH-1:0]};
  endfunction

  logic [LEAVES*SW-1:0] leaf_mg_d, leaf_mg_q;
  logic [LEAVES*SW-1:0] leaf_eg_d, leaf_eg_q;

  always_comb begin
    leaf_mg_d = '0;
    leaf_eg_d = '0;
    for (int k = 0; k < TERM_COUNT; k++) begin
      leaf_mg_d[term_lsb(k, SW) +: SW] =
        sext(eval_mg_in[term_lsb(k, EVAL_WIDTH) +: EVAL_WIDTH]);
      leaf_eg_d[term_lsb(k, SW) +: SW] =
        sext(eval_eg_in[term_lsb(k, EVAL_WIDTH) +: EVAL_WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    leaf_mg_q <= leaf_mg_d;
    leaf_eg_q <= leaf_eg_d;
  end

  // Heap layout: level n starts at node 2*LEAVES - 2*(LEAVES >> n).
  logic [NODES*SW-1:0] node_mg;
  logic [NODES*SW-1:0] node_eg;

  assign node_mg[LEAVES*SW-1:0] = leaf_mg_q;
  assign node_eg[LEAVES*SW-1:0] = leaf_eg_q;

  for (genvar n = 1; n <= LEVELS; n++) begin : g_lvl
    localparam int CNT     = LEAVES >> (n - 1);
    localparam int IN_OFF  = 2 * LEAVES - 2 * CNT;
    localparam int OUT_OFF = 2 * LEAVES - CNT;

    evaluate_mob_sum_level #(.N(CNT), .W(SW)) u_mg (
      .clk (clk),
      .d_i (node_mg[IN_OFF*SW +: CNT*SW]),
      .q_o (node_mg[OUT_OFF*SW +: (CNT/2)*SW])
    );

    evaluate_mob_sum_level #(.N(CNT), .W(SW)) u_eg (
      .clk (clk),
      .d_i (node_eg[IN_OFF*SW +: CNT*SW]),
      .q_o (node_eg[OUT_OFF*SW +: (CNT/2)*SW])
    );
  end

  logic [DEPTH-1:0]      vld_d, vld_q;
  logic [EVAL_WIDTH-1:0] mg_d, mg_q;
  logic [EVAL_WIDTH-1:0] eg_d, eg_q;
  logic                  sat_d, sat_q;
  logic [EVAL_WIDTH:0]   cl_mg, cl_eg;

  always_comb begin
    vld_d = {vld_q[DEPTH-2:0], board_valid};
    cl_mg = clamp(node_mg[ROOT*SW +: SW]);
    cl_eg = clamp(node_eg[ROOT*SW +: SW]);
    mg_d  = mg_q;
    eg_d  = eg_q;
    sat_d = sat_q;
    // Root holds this board's sums exactly one cycle before eval_valid.
    if (vld_q[DEPTH-2]) begin
      mg_d  = cl_mg[EVAL_WIDTH-1:0];
      eg_d  = cl_eg[EVAL_WIDTH-1:0];
      sat_d = cl_mg[EVAL_WIDTH] | cl_eg[EVAL_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      mg_q  <= '0;
      eg_q  <= '0;
      sat_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      mg_q  <= mg_d;
      eg_q  <= eg_d;
      sat_q <= sat_d;
    end
  end

  assign eval_valid     = vld_q[DEPTH-1];
  assign eval_mg        = mg_q;
  assign eval_eg        = eg_q;
  assign eval_saturated = sat_q;

endmodule

// File: tb/tb_evaluate_mob_sum.sv
// Bench for evaluate_mob_sum: directed and random boards against a
// cycle-indexed reference of sums, clamps and valid timing.
`timescale 1ns/1ps
module tb_evaluate_mob_sum;

  localparam int EW   = 16;
  localparam int TC   = 512;
  localparam int UL   = 4;
  localparam int LAT  = 15;
  localparam int EW3  = 8;
  localparam int TC3  = 3;
  localparam int LAT3 = 8;

  typedef struct {
    int mg;
    int eg;
    bit sat;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  logic board_valid, board_valid3;
  logic [TC*EW-1:0] mg_in, eg_in;
  logic [TC3*EW3-1:0] mg_in3, eg_in3;
  logic [EW-1:0] eval_mg, eval_eg;
  logic [EW3-1:0] eval_mg3, eval_eg3;
  logic eval_valid, eval_saturated;
  logic eval_valid3, eval_saturated3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int b_mg[], b_eg[], b3_mg[], b3_eg[];
  logic [TC*EW-1:0] pend_mg[int], pend_eg[int];
  logic [TC3*EW3-1:0] pend3_mg[int], pend3_eg[int];
  res_t exp_m[int], exp3[int];
  res_t last, last3;

  always #5 clk = ~clk;

  evaluate_mob_sum #(
    .EVAL_WIDTH(EW), .TERM_COUNT(TC), .UPSTREAM_LATENCY(UL)
  ) dut (
    .clk(clk), .reset(reset), .board_valid(board_valid),
    .eval_mg_in(mg_in), .eval_eg_in(eg_in),
    .eval_mg(eval_mg), .eval_eg(eval_eg),
    .eval_valid(eval_valid), .eval_saturated(eval_saturated)
  );

  evaluate_mob_sum #(
    .EVAL_WIDTH(EW3), .TERM_COUNT(TC3), .UPSTREAM_LATENCY(UL)
  ) dut3 (
    .clk(clk), .reset(reset), .board_valid(board_valid3),
    .eval_mg_in(mg_in3), .eval_eg_in(eg_in3),
    .eval_mg(eval_mg3), .eval_eg(eval_eg3),
    .eval_valid(eval_valid3), .eval_saturated(eval_saturated3)
  );

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed %0d expected %0d",
             tag, cyc, obs, expv);
    end
  endtask

  function automatic res_t ref_sum(input int t_mg[], input int t_eg[],
                                   input int ew);
    res_t r;
    longint smg = 0, seg = 0;
    longint hi = (longint'(1) << (ew - 1)) - 1;
    longint lo = -hi - 1;
    foreach (t_mg[k]) smg += t_mg[k];
    foreach (t_eg[k]) seg += t_eg[k];
    r.sat = (smg > hi) || (smg < lo) || (seg > hi) || (seg < lo);
    r.mg = int'((smg > hi) ? hi : (smg < lo) ? lo : smg);
    r.eg = int'((seg > hi) ? hi : (seg < lo) ? lo : seg);
    return r;
  endfunction

  function automatic logic [TC*EW-1:0] pack(input int t[]);
    logic [TC*EW-1:0] v = '0;
    foreach (t[k]) v[k*EW +: EW] = EW'(t[k]);
    return v;
  endfunction

  function automatic logic [TC3*EW3-1:0] pack3(input int t[]);
    logic [TC3*EW3-1:0] v = '0;
    foreach (t[k]) v[k*EW3 +: EW3] = EW3'(t[k]);
    return v;
  endfunction

  function automatic int rterm(input int mode);
    case (mode)
      0:       return int'($urandom_range(0, 100)) - 50;
      1:       return int'($urandom_range(0, 2000)) - 1000;
      default: return int'($signed(16'($urandom())));
    endcase
  endfunction

  task automatic zero_terms();
    foreach (b_mg[k]) begin b_mg[k] = 0; b_eg[k] = 0; end
    foreach (b3_mg[k]) begin b3_mg[k] = 0; b3_eg[k] = 0; end
  endtask

  // One clock: drive this cycle's inputs, then check the next cycle.
  task automatic step(input bit bv, input bit bv3, input bit rst);
    int c;
    int dead[$];
    c = cyc;
    reset = rst;
    board_valid = bv;
    board_valid3 = bv3;
    if (pend_mg.exists(c)) begin
      mg_in = pend_mg[c];
      eg_in = pend_eg[c];
    end else begin
      for (int i = 0; i < TC*EW/32; i++) begin
        mg_in[i*32 +: 32] = $urandom();
        eg_in[i*32 +: 32] = $urandom();
      end
    end
    if (pend3_mg.exists(c)) begin
      mg_in3 = pend3_mg[c];
      eg_in3 = pend3_eg[c];
    end else begin
      mg_in3 = 24'($urandom());
      eg_in3 = 24'($urandom());
    end
    if (rst) begin
      foreach (exp_m[k]) if (k > c) dead.push_back(k);
      foreach (dead[i]) exp_m.delete(dead[i]);
      dead.delete();
      foreach (exp3[k]) if (k > c) dead.push_back(k);
      foreach (dead[i]) exp3.delete(dead[i]);
    end else begin
      if (bv) begin
        pend_mg[c+UL] = pack(b_mg);
        pend_eg[c+UL] = pack(b_eg);
        exp_m[c+LAT] = ref_sum(b_mg, b_eg, EW);
      end
      if (bv3) begin
        pend3_mg[c+UL] = pack3(b3_mg);
        pend3_eg[c+UL] = pack3(b3_eg);
        exp3[c+LAT3] = ref_sum(b3_mg, b3_eg, EW3);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      last = '{mg: 0, eg: 0, sat: 0};
      last3 = '{mg: 0, eg: 0, sat: 0};
    end
    if (exp_m.exists(cyc)) last = exp_m[cyc];
    if (exp3.exists(cyc)) last3 = exp3[cyc];
    chk("valid", eval_valid, exp_m.exists(cyc));
    chk("mg", $signed(eval_mg), last.mg);
    chk("eg", $signed(eval_eg), last.eg);
    chk("sat", eval_saturated, last.sat);
    chk("valid3", eval_valid3, exp3.exists(cyc));
    chk("mg3", $signed(eval_mg3), last3.mg);
    chk("eg3", $signed(eval_eg3), last3.eg);
    chk("sat3", eval_saturated3, last3.sat);
  endtask

  initial begin
    int c0, mode;
    b_mg = new[TC];
    b_eg = new[TC];
    b3_mg = new[TC3];
    b3_eg = new[TC3];
    zero_terms();
    last = '{mg: 0, eg: 0, sat: 0};
    last3 = '{mg: 0, eg: 0, sat: 0};
    reset = 1'b1;
    board_valid = 1'b0;
    board_valid3 = 1'b0;
    mg_in = '0;
    eg_in = '0;
    mg_in3 = '0;
    eg_in3 = '0;

    repeat (3) step(0, 0, 1);
    while (cyc < 10) step(0, 0, 0);

    // all-zero board at cycle 10, result due at 25
    step(1, 0, 0);

    zero_terms();
    b_mg[0] = 5;
    b_mg[511] = -3;
    b_eg[100] = 7;
    step(1, 0, 0);

    foreach (b_mg[k]) begin b_mg[k] = 100; b_eg[k] = -100; end
    step(1, 0, 0);

    for (int i = 1; i <= 3; i++) begin
      zero_terms();
      b_mg[i*7] = 10 * i;
      b_eg[200] = 10 * i;
      b3_mg[0] = 127;
      b3_mg[1] = 127;
      b3_mg[2] = -1;
      b3_eg[i-1] = -5 * i;
      step(1, 1, 0);
    end
    repeat (20) step(0, 0, 0);

    // reset eight cycles into a board, then a fresh board two later
    zero_terms();
    b_mg[3] = 42;
    b3_mg[1] = 9;
    c0 = cyc;
    step(1, 1, 0);
    while (cyc < c0 + 8) step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    b_eg[9] = -77;
    b3_eg[2] = 33;
    step(1, 1, 0);
    repeat (20) step(0, 0, 0);

    step(1, 1, 1);
    repeat (20) step(0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      mode = int'($urandom_range(0, 2));
      foreach (b_mg[k]) begin
        b_mg[k] = rterm(mode);
        b_eg[k] = rterm(mode);
      end
      foreach (b3_mg[k]) begin
        b3_mg[k] = int'($signed(8'($urandom())));
        b3_eg[k] = int'($signed(8'($urandom())));
      end
      step(1, 1'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 3)) step(0, 0, 0);
    end
    repeat (25) step(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/evaluate_mob_sum.md
Name: evaluate_mob_sum

Overview:
- Downstream reduction stage for the per-square mobility evaluators. Each evaluator instance (one per attacking piece type × colour × square) emits signed midgame/endgame mobility terms every cycle.
- This block aligns a board-valid strobe with those terms and sums them through a registered binary adder tree. It then saturates the totals and presents one signed mobility score pair, with a valid strobe, to the top-level evaluator.
- Fully pipelined: accepts a new board every cycle.

Parameters:
- EVAL_WIDTH, 16, signed width of every input term and of both outputs.
- TERM_COUNT, 512, number of per-square evaluator outputs summed (4 piece types × 2 colours × 64). Any value ≥ 2 is legal.
- UPSTREAM_LATENCY, 4, cycles from board_valid high to the matching terms being stable on eval_mg_in/eval_eg_in.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- board_valid  input  1  board presented to the upstream evaluators this cycle
- eval_mg_in  input  TERM_COUNT*EVAL_WIDTH  packed signed midgame terms; term k at [k*EVAL_WIDTH +: EVAL_WIDTH]
- eval_eg_in  input  TERM_COUNT*EVAL_WIDTH  packed signed endgame terms, same packing
- eval_mg  output  EVAL_WIDTH  signed saturated midgame mobility sum
- eval_eg  output  EVAL_WIDTH  signed saturated endgame mobility sum
- eval_valid  output  1  one-cycle strobe; eval_mg/eval_eg correspond to one board_valid
- eval_saturated  output  1  qualified by eval_valid; high when either sum was clamped

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high (reset).
- Constants:
  - LEVELS = clog2(TERM_COUNT).
  - SUM_WIDTH = EVAL_WIDTH + LEVELS.
- Input capture (stage 0):
  - Register all TERM_COUNT terms, sign-extended to SUM_WIDTH.
  - Pad to 2^LEVELS leaves with zeros.
- Tree: LEVELS registered levels. Level n holds 2^(LEVELS-n) partial sums; each is the sum of two level n-1 entries. Full SUM_WIDTH arithmetic, no intermediate overflow possible.
- Saturation (final stage, registered):
  - Root > 2^(EVAL_WIDTH-1)-1 → clamp to max.
  - Root < -2^(EVAL_WIDTH-1) → clamp to min.
  - Otherwise truncate to EVAL_WIDTH.
  - eval_saturated = OR of the mg and eg clamp flags.
- Valid alignment:
  - board_valid enters a shift register of depth UPSTREAM_LATENCY + 1 + LEVELS + 1.
  - Its tap drives eval_valid.
  - Total latency board_valid → eval_valid = UPSTREAM_LATENCY + LEVELS + 2 cycles. Defaults: 4 + 9 + 2 = 15.
  - Stage 0 samples the inputs on the cycle the delayed valid indicates; data registers update every cycle regardless.
- Back-to-back operation:
  - Consecutive board_valid pulses yield consecutive eval_valid pulses, in order.
  - Gaps are preserved exactly.
  - No stall, no backpressure.
- Reset:
  - Clears the entire valid shift register, eval_valid, eval_saturated, eval_mg and eval_eg to 0.
  - Tree data registers need not be reset.
  - Reset mid-operation discards every in-flight board; no eval_valid for them.
  - A board_valid asserted in the same cycle as reset is dropped.
  - The first board_valid after reset deasserts produces eval_valid exactly 15 cycles later (default parameters).
- Outputs when eval_valid is low: hold the previous values (only the final stage updates, gated by the delayed valid). Consumers must not sample them.
- Non-power-of-two TERM_COUNT: padded leaves contribute 0, so the result is unaffected.

Decomposition:
- Shared package (vchess.vh): EVAL_WIDTH default, mobility term count per piece type. The per-term packing macro is shared with the per-square evaluators.
- Sub-module evaluate_mob_sum_level:
  - One registered tree level, parameterised by input count and width.
  - Generates N/2 registered adders.
  - Instantiated LEVELS times from a generate loop in evaluate_mob_sum.
- Saturation and valid delay line live in the top module.

Test Plan:
- All terms 0, single board_valid at cycle 10 → eval_valid high only at cycle 25; eval_mg = eval_eg = 0; eval_saturated = 0.
- Term 0 mg = +5, term 511 mg = -3, term 100 eg = +7, rest 0 → eval_mg = 2, eval_eg = 7.
- All 512 mg terms = +100 → sum 51200 > 32767 → eval_mg = 32767, eval_saturated = 1. All eg terms = -100 → eval_eg = -32768.
- board_valid on 3 consecutive cycles, inputs changed each cycle (sums 10, 20, 30) → eval_valid 3 consecutive cycles with 10, 20, 30 in order.
- board_valid at cycle 10, reset at cycle 18 → no eval_valid at cycle 25. A board_valid at cycle 20 → eval_valid at cycle 35.
- TERM_COUNT = 3, EVAL_WIDTH = 8, terms 127, 127, -1 → clamp to 127, eval_saturated = 1. Latency = UPSTREAM_LATENCY + 2 + 2.
